// File: rtl/exe_controller_if.sv
// exe_controller_if: bundles the execute-stage control bus between the pipeline
// and the execute controller.
//   master - pipeline side: drives ID/EX/MEM/WB control fields, ALU flags and
//            SRAM status; observes stalls, selects, status and error.
//   slave  - controller side (exe_controller).
// Outputs suffixed _c are combinational; status_nzcv and mem_error are registered.
interface exe_controller_if;
  localparam int unsigned REG_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NZCV_W = 4;

  // ID stage
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  // EX stage
  logic             ex_valid;
  logic [REG_W-1:0] ex_src1;
  logic [REG_W-1:0] ex_src2;
  logic             ex_wb_en;
  logic             ex_mem_read;
  logic             ex_s_bit;
  logic             ex_branch;
  logic [REG_W-1:0] ex_dest;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  // MEM / WB stages
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             wb_wb_en;
  logic [REG_W-1:0] wb_dest;
  logic             mem_access;
  logic             sram_ready;
  // controller outputs
  logic              sram_req_c;
  logic              freeze_c;
  logic              hazard_stall_c;
  logic              flush_c;
  logic [NZCV_W-1:0] status_nzcv;
  logic [SEL_W-1:0]  fwd_sel1_c;
  logic [SEL_W-1:0]  fwd_sel2_c;
  logic              mem_error;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src,
    output ex_valid, ex_src1, ex_src2, ex_wb_en, ex_mem_read, ex_s_bit, ex_branch, ex_dest,
    output alu_n, alu_z, alu_c, alu_v,
    output mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_access, sram_ready,
    input  sram_req_c, freeze_c, hazard_stall_c, flush_c, status_nzcv,
    input  fwd_sel1_c, fwd_sel2_c, mem_error
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src,
    input  ex_valid, ex_src1, ex_src2, ex_wb_en, ex_mem_read, ex_s_bit, ex_branch, ex_dest,
    input  alu_n, alu_z, alu_c, alu_v,
    input  mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_access, sram_ready,
    output sram_req_c, freeze_c, hazard_stall_c, flush_c, status_nzcv,
    output fwd_sel1_c, fwd_sel2_c, mem_error
  );
endinterface

// File: rtl/exe_controller.sv
// exe_controller: execute-stage sequencing for the 5-stage ARM pipeline.
// Owns the NZCV status register, detects RAW hazards, generates operand
// forwarding selects, issues branch flushes and freezes the pipeline while the
// shared SRAM completes a MEM-stage access.
// Ports:
//   i_clk    - pipeline clock, rising edge
//   i_rst    - asynchronous active-low reset
//   io_ctrl  - exe_controller_if.slave control bus
// Parameter TIMEOUT (1..255): REQ cycles waited for sram_ready before aborting.
// Macro FORWARDING_EN: when defined, EX operands are forwarded from MEM/WB and
// only load-use stalls; otherwise selects are tied to the register file and any
// pending EX/MEM write to an ID source stalls.
module exe_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  exe_controller_if.slave io_ctrl
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NZCV_W = 4;
  // Last REQ cycle index before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_mem_error;
  logic               w_mem_error_nxt;
  logic [NZCV_W-1:0]  r_nzcv;
  logic               w_sram_req;
  logic               w_freeze;
  logic               w_flush;
  logic               w_hazard_raw;
  logic               w_id_hit_ex;
  logic               w_id_hit_mem;
  logic [SEL_W-1:0]   w_fwd_sel1;
  logic [SEL_W-1:0]   w_fwd_sel2;

  // SRAM access FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_error <= w_mem_error_nxt;
    end
  end

  // SRAM access FSM next state; DONE leaves freeze low for one advance cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_error_nxt = r_mem_error;
    w_sram_req      = 1'b0;
    w_freeze        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_ctrl.mem_access) begin
          w_sram_req  = 1'b1;
          w_freeze    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_sram_req = 1'b1;
        w_freeze   = 1'b1;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (io_ctrl.sram_ready) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt     = S_DONE;
          w_mem_error_nxt = 1'b1;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status register: S-instructions update flags only when the pipe advances
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_nzcv <= '0;
    end else if (io_ctrl.ex_valid && io_ctrl.ex_s_bit && !w_freeze) begin
      r_nzcv <= {io_ctrl.alu_n, io_ctrl.alu_z, io_ctrl.alu_c, io_ctrl.alu_v};
    end
  end

  // ID instruction reads a given register (src2 only when it is used)
  assign w_id_hit_ex  = io_ctrl.id_valid &&
                        ((io_ctrl.id_src1 == io_ctrl.ex_dest) ||
                         (io_ctrl.id_two_src && (io_ctrl.id_src2 == io_ctrl.ex_dest)));
  assign w_id_hit_mem = io_ctrl.id_valid &&
                        ((io_ctrl.id_src1 == io_ctrl.mem_dest) ||
                         (io_ctrl.id_two_src && (io_ctrl.id_src2 == io_ctrl.mem_dest)));

`ifdef FORWARDING_EN
  // Forwarding selects: the younger MEM result wins over WB
  always_comb begin
    w_fwd_sel1 = SEL_RF;
    w_fwd_sel2 = SEL_RF;
    if (io_ctrl.mem_wb_en && (io_ctrl.mem_dest == io_ctrl.ex_src1)) w_fwd_sel1 = SEL_MEM;
    else if (io_ctrl.wb_wb_en && (io_ctrl.wb_dest == io_ctrl.ex_src1)) w_fwd_sel1 = SEL_WB;
    if (io_ctrl.mem_wb_en && (io_ctrl.mem_dest == io_ctrl.ex_src2)) w_fwd_sel2 = SEL_MEM;
    else if (io_ctrl.wb_wb_en && (io_ctrl.wb_dest == io_ctrl.ex_src2)) w_fwd_sel2 = SEL_WB;
  end

  // Only a load result cannot be forwarded in time
  assign w_hazard_raw = io_ctrl.ex_valid && io_ctrl.ex_mem_read && io_ctrl.ex_wb_en && w_id_hit_ex;
`else
  logic w_unused;

  assign w_fwd_sel1   = SEL_RF;
  assign w_fwd_sel2   = SEL_RF;
  // Without forwarding, any pending write to an ID source must drain first
  assign w_hazard_raw = (io_ctrl.ex_valid && io_ctrl.ex_wb_en && w_id_hit_ex) ||
                        (io_ctrl.mem_wb_en && w_id_hit_mem);
  assign w_unused     = ^{io_ctrl.ex_src1, io_ctrl.ex_src2, io_ctrl.ex_mem_read,
                          io_ctrl.wb_wb_en, io_ctrl.wb_dest};
`endif

  // A taken branch squashes the ID instruction, so its stall is moot
  assign w_flush = io_ctrl.ex_valid && io_ctrl.ex_branch && !w_freeze;

  assign io_ctrl.sram_req_c     = w_sram_req;
  assign io_ctrl.freeze_c       = w_freeze;
  assign io_ctrl.flush_c        = w_flush;
  assign io_ctrl.hazard_stall_c = w_hazard_raw && !w_flush;
  assign io_ctrl.fwd_sel1_c     = w_fwd_sel1;
  assign io_ctrl.fwd_sel2_c     = w_fwd_sel2;
  assign io_ctrl.status_nzcv    = r_nzcv;
  assign io_ctrl.mem_error      = r_mem_error;
endmodule
